// File: rtl/risc16_core.sv
// Single-cycle 16-bit load/store RISC core with internal instruction ROM and data RAM.
// Optional HALT opcode and halted output enabled by defining RISC16_HALT_EN.
module risc16_core #(
  parameter int unsigned  IMEM_DEPTH = 16,
  parameter int unsigned  DMEM_DEPTH = 8,
  // Word i of the ROM image lives in IMEM_INIT[i*16 +: 16]; words beyond 16 read as zero.
  parameter logic [255:0] IMEM_INIT  = {
    16'h0000, 16'hD000, 16'hC040, 16'hB040,
    16'h2000, 16'h9050, 16'h8050, 16'h7050,
    16'h6050, 16'h5050, 16'h4010, 16'h3050,
    16'h1280, 16'h2050, 16'h0441, 16'h0400
  }
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc,
  output logic [15:0] instr
`ifdef RISC16_HALT_EN
  ,
  output logic        halted
`endif
);

  typedef enum logic [3:0] {
    OP_LD  = 4'h0, OP_ST  = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_INV = 4'h4, OP_LSL = 4'h5, OP_LSR = 4'h6, OP_AND = 4'h7,
    OP_OR  = 4'h8, OP_SLT = 4'h9, OP_RSA = 4'hA, OP_BEQ = 4'hB,
    OP_BNE = 4'hC, OP_JMP = 4'hD, OP_RSE = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  function automatic logic [DMEM_DEPTH*16-1:0] dmem_image();
    logic [DMEM_DEPTH*16-1:0] img;
    img = '0;
    for (int unsigned i = 0; i < DMEM_DEPTH; i++) img[i*16 +: 16] = 16'(i + 1);
    return img;
  endfunction

  // Data RAM keeps its power-up image across reset, so it is an initialised, never-reset store.
  logic [DMEM_DEPTH*16-1:0] dmem_q = dmem_image();

  logic [15:0] regs [8];
  logic [31:0] imem_idx;
  logic [31:0] dmem_idx;
  opcode_e     op;
  logic [2:0]  ra_i, rb_i, rd_i;
  logic [15:0] rav, rbv, imm, addr, rdata, pc_next, reg_wd;
  logic [2:0]  reg_wa;
  logic        reg_we, mem_we, zero_flag;
`ifdef RISC16_HALT_EN
  logic        halt_q;
`endif

  always_comb begin
    imem_idx = 32'(pc) % IMEM_DEPTH;
    instr    = (imem_idx < 32'd16) ? IMEM_INIT[imem_idx*16 +: 16] : '0;
  end

  always_comb begin
    op        = opcode_e'(instr[15:12]);
    ra_i      = instr[11:9];
    rb_i      = instr[8:6];
    rd_i      = instr[5:3];
    imm       = {{10{instr[5]}}, instr[5:0]};
    rav       = regs[ra_i];
    rbv       = regs[rb_i];
    addr      = rav + imm;
    dmem_idx  = 32'(addr) % DMEM_DEPTH;
    rdata     = dmem_q[dmem_idx*16 +: 16];
    zero_flag = ((rav - rbv) == 16'h0000);
  end

  always_comb begin
    pc_next = pc + 16'd1;
    reg_we  = 1'b0;
    reg_wa  = rd_i;
    reg_wd  = '0;
    mem_we  = 1'b0;
    case (op)
      OP_LD:  begin reg_we = 1'b1; reg_wa = rb_i; reg_wd = rdata; end
      OP_ST:  mem_we = 1'b1;
      OP_ADD: begin reg_we = 1'b1; reg_wd = rav + rbv; end
      OP_SUB: begin reg_we = 1'b1; reg_wd = rav - rbv; end
      OP_INV: begin reg_we = 1'b1; reg_wd = ~rav; end
      OP_LSL: begin reg_we = 1'b1; reg_wd = rav << rbv[3:0]; end
      OP_LSR: begin reg_we = 1'b1; reg_wd = rav >> rbv[3:0]; end
      OP_AND: begin reg_we = 1'b1; reg_wd = rav & rbv; end
      OP_OR:  begin reg_we = 1'b1; reg_wd = rav | rbv; end
      OP_SLT: begin reg_we = 1'b1; reg_wd = {15'b0, rav < rbv}; end
      OP_BEQ: if (zero_flag)  pc_next = pc + 16'd1 + imm;
      OP_BNE: if (!zero_flag) pc_next = pc + 16'd1 + imm;
      OP_JMP: pc_next = {4'b0000, instr[11:0]};
`ifdef RISC16_HALT_EN
      // The halting instruction stays at pc, so holding here also covers the halted state.
      OP_HLT: pc_next = pc;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (reg_we) regs[reg_wa] <= reg_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) dmem_q[dmem_idx*16 +: 16] <= rbv;
  end

`ifdef RISC16_HALT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              halt_q <= 1'b0;
    else if (op == OP_HLT)  halt_q <= 1'b1;
  end

  assign halted = halt_q;
`endif

endmodule

// File: tb/tb_risc16_core.sv
// Bench for risc16_core: default-ROM and custom-ROM cores against an instruction-level interpreter.
module tb_risc16_core;

  localparam logic [255:0] ROM_DEF = {
    16'h0000, 16'hD000, 16'hC040, 16'hB040,
    16'h2000, 16'h9050, 16'h8050, 16'h7050,
    16'h6050, 16'h5050, 16'h4010, 16'h3050,
    16'h1280, 16'h2050, 16'h0441, 16'h0400
  };
  // LD r1,[r0]; LD r3,[r1-2]; LSL r4=r3<<r1; ST [r1-2]=r4; SLT r5; BEQ r0,r0,+3;
  // NOP; NOP; ADD r2=r2+r1; BNE r0,r1,-2; then unreached words.
  localparam logic [255:0] ROM_CUS = {
    16'hF000, 16'hF000, 16'hE000, 16'h0000,
    16'h0000, 16'hA000, 16'hC07E, 16'h2450,
    16'hA000, 16'hA000, 16'hB003, 16'h92E8,
    16'h133E, 16'h5660, 16'h02FE, 16'h0040
  };

  logic        clk = 1'b0;
  logic        rst_d, rst_c;
  logic [15:0] pc_d, instr_d, pc_c, instr_c;
`ifdef RISC16_HALT_EN
  logic        halted_d, halted_c;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] rom   [2][16];
  logic [15:0] m_pc  [2];
  logic [15:0] m_reg [2][8];
  logic [15:0] m_mem [2][8];
  logic        in_rst [2];

  always #5 clk = ~clk;

  risc16_core #(.IMEM_DEPTH(16), .DMEM_DEPTH(8), .IMEM_INIT(ROM_DEF)) u_def (
    .clk(clk), .reset(rst_d), .pc(pc_d), .instr(instr_d)
`ifdef RISC16_HALT_EN
    , .halted(halted_d)
`endif
  );

  risc16_core #(.IMEM_DEPTH(16), .DMEM_DEPTH(8), .IMEM_INIT(ROM_CUS)) u_cus (
    .clk(clk), .reset(rst_c), .pc(pc_c), .instr(instr_c)
`ifdef RISC16_HALT_EN
    , .halted(halted_c)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_pc[k] = '0;
    for (int i = 0; i < 8; i++) m_reg[k][i] = '0;
  endtask

  // Executes one instruction at the ISA level for core k.
  task automatic model_step(input int k);
    logic [15:0] w, a, b, se, ea, npc;
    w   = rom[k][m_pc[k] % 16];
    a   = m_reg[k][w[11:9]];
    b   = m_reg[k][w[8:6]];
    se  = {{10{w[5]}}, w[5:0]};
    ea  = a + se;
    npc = m_pc[k] + 16'd1;
    case (w[15:12])
      4'h0: m_reg[k][w[8:6]] = m_mem[k][ea % 8];
      4'h1: m_mem[k][ea % 8] = b;
      4'h2: m_reg[k][w[5:3]] = a + b;
      4'h3: m_reg[k][w[5:3]] = a - b;
      4'h4: m_reg[k][w[5:3]] = ~a;
      4'h5: m_reg[k][w[5:3]] = a << b[3:0];
      4'h6: m_reg[k][w[5:3]] = a >> b[3:0];
      4'h7: m_reg[k][w[5:3]] = a & b;
      4'h8: m_reg[k][w[5:3]] = a | b;
      4'h9: m_reg[k][w[5:3]] = (a < b) ? 16'd1 : 16'd0;
      4'hB: if (a == b) npc = m_pc[k] + 16'd1 + se;
      4'hC: if (a != b) npc = m_pc[k] + 16'd1 + se;
      4'hD: npc = {4'h0, w[11:0]};
      default: ;
    endcase
    m_pc[k] = npc;
  endtask

  task automatic cmp_all(input int k);
    logic [15:0] o;
    string p;
    p = (k == 0) ? "def" : "cus";
    chk({p, "_pc"}, (k == 0) ? pc_d : pc_c, m_pc[k]);
    chk({p, "_instr"}, (k == 0) ? instr_d : instr_c, rom[k][m_pc[k] % 16]);
    for (int i = 0; i < 8; i++) begin
      o = (k == 0) ? u_def.regs[i] : u_cus.regs[i];
      chk($sformatf("%s_r%0d", p, i), o, m_reg[k][i]);
    end
    for (int i = 0; i < 8; i++) begin
      o = (k == 0) ? u_def.dmem_q[i*16 +: 16] : u_cus.dmem_q[i*16 +: 16];
      chk($sformatf("%s_dmem%0d", p, i), o, m_mem[k][i]);
    end
`ifdef RISC16_HALT_EN
    chk({p, "_halted"}, {15'b0, (k == 0) ? halted_d : halted_c}, 16'd0);
`endif
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!in_rst[k]) model_step(k);
      cmp_all(k);
    end
  endtask

  initial begin
    logic [15:0] r2_exp [7];
    int sel, hold;
    r2_exp = '{16'hFFFF, 16'hFFFE, 16'h0004, 16'h0000, 16'h0000, 16'h0003, 16'h0001};

    for (int i = 0; i < 16; i++) begin
      rom[0][i] = ROM_DEF[i*16 +: 16];
      rom[1][i] = ROM_CUS[i*16 +: 16];
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 16'(i + 1);
      model_reset(k);
      in_rst[k] = 1'b1;
    end

    rst_d = 1'b1;
    rst_c = 1'b1;
    #2;
    cmp_all(0);
    cmp_all(1);
    @(negedge clk);
    rst_d = 1'b0;
    rst_c = 1'b0;
    in_rst[0] = 1'b0;
    in_rst[1] = 1'b0;

    // Directed walk through the default program, with the custom core running alongside.
    edge_step(); chk("e1_r0", u_def.regs[0], 16'h0001);
    edge_step(); chk("e2_r1", u_def.regs[1], 16'h0002);
    edge_step(); chk("e3_r2", u_def.regs[2], 16'h0003);
    edge_step(); chk("e4_dmem2", u_def.dmem_q[2*16 +: 16], 16'h0003);
    for (int e = 0; e < 7; e++) begin
      edge_step();
      chk($sformatf("e%0d_r2", e + 5), u_def.regs[2], r2_exp[e]);
      if (e == 1) chk("cus_beq_pc", pc_c, 16'd9);
      if (e == 2) chk("cus_bne_pc", pc_c, 16'd8);
    end
    edge_step(); chk("e12_r0", u_def.regs[0], 16'h0002);
    edge_step(); chk("e13_beq_pc", pc_d, 16'd13);
    edge_step(); chk("e14_bne_pc", pc_d, 16'd14);
    edge_step(); chk("e15_jmp_pc", pc_d, 16'd0);
    repeat (7) edge_step();
    chk("pre_rst_pc", pc_d, 16'd7);

    // Asynchronous reset between edges; RAM contents written earlier must survive.
    #2;
    rst_d = 1'b1;
    in_rst[0] = 1'b1;
    model_reset(0);
    #1;
    chk("async_pc", pc_d, 16'd0);
    chk("async_r2", u_def.regs[2], 16'h0000);
    chk("async_dmem2", u_def.dmem_q[2*16 +: 16], 16'h0003);
    cmp_all(0);
    @(negedge clk);
    rst_d = 1'b0;
    in_rst[0] = 1'b0;

    // Free run with randomly placed asynchronous resets of random length.
    for (int it = 0; it < 300; it++) begin
      edge_step();
      if ($urandom_range(0, 15) == 0) begin
        sel  = $urandom_range(0, 2);
        hold = $urandom_range(0, 2);
        #($urandom_range(1, 2));
        if (sel != 1) begin rst_d = 1'b1; in_rst[0] = 1'b1; model_reset(0); end
        if (sel != 0) begin rst_c = 1'b1; in_rst[1] = 1'b1; model_reset(1); end
        #1;
        cmp_all(0);
        cmp_all(1);
        repeat (hold) edge_step();
        @(negedge clk);
        rst_d = 1'b0;
        rst_c = 1'b0;
        in_rst[0] = 1'b0;
        in_rst[1] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
